// File: rtl/digit_string_renderer.sv
// N-digit decimal sprite renderer: binary -> BCD, glyph ROM addressing.
// Optional: LEADING_ZERO_BLANK_EN blanks leading zero digits.
module digit_string_renderer #(
    parameter int          NUM_DIGITS        = 3,
    parameter int          VALUE_WIDTH       = 10,
    parameter int          SPRITE_WIDTH      = 10,
    parameter int          SPRITE_HEIGHT     = 13,
    parameter int          GLYPH_ADDR_WIDTH  = 11,
    parameter int          ROM_LATENCY       = 1,
    parameter logic [7:0]  TRANSPARENT_COLOR = 8'b11100011
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [VALUE_WIDTH-1:0]      value,
    input  logic                        value_valid,
    output logic                        busy,
    output logic                        overflow,
    input  logic [9:0]                  relative_x,
    input  logic [9:0]                  relative_y,
    output logic [GLYPH_ADDR_WIDTH-1:0] glyph_address,
    input  logic [7:0]                  glyph_data,
    output logic [7:0]                  pixel_data
);

    localparam logic [31:0] MAX_VALUE = 32'(10**NUM_DIGITS - 1);
    localparam int BCD_W = 4 * NUM_DIGITS;
    localparam int CNT_W = $clog2(VALUE_WIDTH + 1);
    localparam logic [VALUE_WIDTH-1:0] MAX_SAT = VALUE_WIDTH'(MAX_VALUE);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(VALUE_WIDTH - 1);
    localparam logic [31:0] GLYPH_WORDS = 32'(SPRITE_WIDTH * SPRITE_HEIGHT);
    localparam logic [31:0] ROW_LIMIT = 32'(SPRITE_HEIGHT);
    localparam logic [31:0] COL_LIMIT = 32'(NUM_DIGITS * SPRITE_WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CONVERT,
        S_COMMIT
    } state_t;

    state_t                 r_state;
    logic                   r_busy;
    logic                   r_ovf;
    logic                   r_sat;
    logic [VALUE_WIDTH-1:0] r_bin;
    logic [BCD_W-1:0]       r_bcd;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_pend;
    logic [VALUE_WIDTH-1:0] r_pend_val;
    logic                   r_pend_sat;
    logic [3:0]             r_disp [NUM_DIGITS];
    logic [ROM_LATENCY-1:0] r_pipe;

    logic                   w_in_sat;
    logic [VALUE_WIDTH-1:0] w_in_val;
    logic                   w_ld_sat;
    logic [VALUE_WIDTH-1:0] w_ld_val;
    logic [BCD_W-1:0]       w_adj;
    logic [BCD_W+VALUE_WIDTH-1:0] w_shift;
    logic [31:0]            w_x;
    logic [31:0]            w_y;
    logic [31:0]            w_cx;
    logic [3:0]             w_dig;
    logic                   w_in_range;
    logic                   w_show;
    logic [31:0]            w_addr;

    // Saturate the incoming value to what the display can show
    always_comb begin
        w_in_sat = (32'(value) > MAX_VALUE);
        w_in_val = w_in_sat ? MAX_SAT : value;
        w_ld_sat = value_valid ? w_in_sat : r_pend_sat;
        w_ld_val = value_valid ? w_in_val : r_pend_val;
    end

    // One double-dabble step: add 3 to nibbles >= 5, then shift left
    always_comb begin
        w_adj = r_bcd;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_shift = {w_adj, r_bin} << 1;
    end

    // Conversion FSM; display registers change only in COMMIT
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_busy     <= 1'b0;
            r_ovf      <= 1'b0;
            r_sat      <= 1'b0;
            r_bin      <= '0;
            r_bcd      <= '0;
            r_cnt      <= '0;
            r_pend     <= 1'b0;
            r_pend_val <= '0;
            r_pend_sat <= 1'b0;
            for (int k = 0; k < NUM_DIGITS; k++) begin
                r_disp[k] <= 4'd0;
            end
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (value_valid || r_pend) begin
                        r_bin   <= w_ld_val;
                        r_sat   <= w_ld_sat;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    {r_bcd, r_bin} <= w_shift;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == LAST_CNT) begin
                        r_state <= S_COMMIT;
                    end
                    if (value_valid) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= w_in_val;
                        r_pend_sat <= w_in_sat;
                    end
                end
                S_COMMIT: begin
                    for (int k = 0; k < NUM_DIGITS; k++) begin
                        r_disp[k] <= r_bcd[4*(NUM_DIGITS-1-k) +: 4];
                    end
                    r_ovf <= r_sat;
                    if (r_pend) begin
                        r_bin   <= r_pend_val;
                        r_sat   <= r_pend_sat;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_pend  <= 1'b0;
                        r_state <= S_CONVERT;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                    // A load landing on COMMIT waits for the next slot
                    if (value_valid) begin
                        r_pend     <= 1'b1;
                        r_pend_val <= w_in_val;
                        r_pend_sat <= w_in_sat;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy     = r_busy;
    assign overflow = r_ovf;

    // Locate digit column by range compare, then form the ROM address
    always_comb begin
        w_x   = 32'(relative_x);
        w_y   = 32'(relative_y);
        w_cx  = '0;
        w_dig = 4'd0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_x >= 32'(i * SPRITE_WIDTH) &&
                w_x < 32'((i + 1) * SPRITE_WIDTH)) begin
                w_cx  = w_x - 32'(i * SPRITE_WIDTH);
                w_dig = r_disp[i];
            end
        end
        w_in_range = (w_y < ROW_LIMIT) && (w_x < COL_LIMIT);
        w_addr = 32'(w_dig) * GLYPH_WORDS
               + w_y * 32'(SPRITE_WIDTH) + w_cx;
    end

    assign glyph_address = w_in_range ?
        GLYPH_ADDR_WIDTH'(w_addr) : '0;

`ifdef LEADING_ZERO_BLANK_EN
    logic w_blank;

    // Blank a digit when it and all digits left of it are zero
    always_comb begin
        logic lz;
        lz      = 1'b1;
        w_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lz = lz && (r_disp[i] == 4'd0);
            if (w_x >= 32'(i * SPRITE_WIDTH) &&
                w_x < 32'((i + 1) * SPRITE_WIDTH)) begin
                w_blank = lz && (i < NUM_DIGITS - 1);
            end
        end
        w_show = w_in_range && !w_blank;
    end
`else
    assign w_show = w_in_range;
`endif

    // Delay the visibility flag to line up with ROM read data
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pipe <= '0;
        end else begin
            r_pipe[0] <= w_show;
            for (int i = 1; i < ROM_LATENCY; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end
        end
    end

    assign pixel_data = r_pipe[ROM_LATENCY-1] ?
        glyph_data : TRANSPARENT_COLOR;

endmodule

// File: tb/tb_digit_string_renderer.sv
// Bench for digit_string_renderer: timeline model plus literal probes.
// Honours LEADING_ZERO_BLANK_EN when compiled with it.
module tb_digit_string_renderer;

    localparam int N  = 3;
    localparam int W  = 10;
    localparam int SW = 10;
    localparam int SH = 13;
    localparam int AW = 11;
    localparam int MAXV = 999;
    localparam logic [7:0] TC = 8'hE3;

    logic          clk = 1'b0;
    logic          rst;
    logic [W-1:0]  value;
    logic          value_valid;
    logic          busy;
    logic          overflow;
    logic [9:0]    relative_x;
    logic [9:0]    relative_y;
    logic [AW-1:0] glyph_address;
    logic [7:0]    glyph_data;
    logic [7:0]    pixel_data;

    int errors = 0;
    int checks = 0;
    bit chk_en = 0;

    digit_string_renderer dut (
        .clk(clk), .rst(rst), .value(value), .value_valid(value_valid),
        .busy(busy), .overflow(overflow),
        .relative_x(relative_x), .relative_y(relative_y),
        .glyph_address(glyph_address), .glyph_data(glyph_data),
        .pixel_data(pixel_data)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_f(input int a);
        return 8'((a * 37 + 11) % 256);
    endfunction

    always @(posedge clk) glyph_data <= rom_f(int'(glyph_address));

    task automatic check(input string n, input logic [31:0] a,
                         input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", n, a, e);
        end
    endtask

    // ---------------- model ----------------
    int m_disp = 0, m_rem = 0, m_fly = 0, m_pendv = 0, m_prev_addr = 0;
    bit m_ovf = 0, m_flyovf = 0, m_pend = 0, m_prev_show = 0;

    function automatic int e_addr(input int x, input int y, input int d);
        int k, dg;
        if (y >= SH || x >= N * SW) return 0;
        k  = x / SW;
        dg = (d / (10 ** (N - 1 - k))) % 10;
        return dg * SW * SH + y * SW + (x - k * SW);
    endfunction

    function automatic bit e_show(input int x, input int y, input int d);
        int k;
        if (y >= SH || x >= N * SW) return 0;
        k = x / SW;
`ifdef LEADING_ZERO_BLANK_EN
        if (k < N - 1 && d / (10 ** (N - 1 - k)) == 0) return 0;
`endif
        return 1;
    endfunction

    task automatic m_start(input int v);
        m_fly    = (v > MAXV) ? MAXV : v;
        m_flyovf = (v > MAXV);
        m_rem    = W + 1;
    endtask

    always @(posedge clk) begin
        m_prev_show = e_show(int'(relative_x), int'(relative_y), m_disp);
        m_prev_addr = e_addr(int'(relative_x), int'(relative_y), m_disp);
        if (rst) begin
            m_disp = 0; m_ovf = 0; m_rem = 0; m_pend = 0;
            m_prev_show = 0;
        end else if (m_rem == 0) begin
            if (value_valid) begin
                m_start(int'(value)); m_pend = 0;
            end else if (m_pend) begin
                m_start(m_pendv); m_pend = 0;
            end
        end else begin
            m_rem--;
            if (m_rem == 0) begin
                m_disp = m_fly;
                m_ovf  = m_flyovf;
                if (m_pend) begin
                    m_start(m_pendv); m_pend = 0;
                end
            end
            if (value_valid) begin
                m_pend = 1; m_pendv = int'(value);
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", 32'(busy), 32'(m_rem > 0));
            check("overflow", 32'(overflow), 32'(m_ovf));
            check("glyph_address", 32'(glyph_address),
                  32'(e_addr(int'(relative_x), int'(relative_y), m_disp)));
            check("pixel_data", 32'(pixel_data),
                  32'(m_prev_show ? rom_f(m_prev_addr) : TC));
        end
    end

    // ---------------- stimulus ----------------
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic load(input int v);
        cyc(1);
        value = W'(v);
        value_valid = 1'b1;
        cyc(1);
        value_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 100) begin
            cyc(1);
            n++;
        end
        if (busy) check("idle_timeout", 32'(busy), 32'd0);
        cyc(1);
    endtask

    task automatic probe(input string nm, input int x, input int y,
                         input int ea, input logic [7:0] ep);
        cyc(1);
        relative_x = 10'(x);
        relative_y = 10'(y);
        @(negedge clk);
        check({nm, "_addr"}, 32'(glyph_address), 32'(ea));
        cyc(1);
        @(negedge clk);
        check({nm, "_pix"}, 32'(pixel_data), 32'(ep));
    endtask

    function automatic logic [7:0] lz_pix(input int a);
`ifdef LEADING_ZERO_BLANK_EN
        return TC;
`else
        return rom_f(a);
`endif
    endfunction

    initial begin
        int n;
        rst = 1'b1; value = '0; value_valid = 1'b0;
        relative_x = '0; relative_y = '0;
        cyc(1);
        chk_en = 1;
        cyc(1);
        rst = 1'b0;

        // reset state and zero display
        probe("zero_x5", 5, 3, 35, lz_pix(35));
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        probe("zero_x15", 15, 3, 35, lz_pix(35));
        probe("zero_x25", 25, 3, 35, rom_f(35));

        // 427 with busy window length
        load(427);
        n = 0;
        while (n < 60) begin
            @(negedge clk);
            if (!busy) break;
            n++;
        end
        check("busy_cycles", 32'(n), 32'd11);
        probe("v427_x12", 12, 0, 262, rom_f(262));
        probe("v427_x0", 0, 0, 520, rom_f(520));
        probe("v427_x20", 20, 0, 910, rom_f(910));

        // saturation
        load(1023);
        wait_idle();
        check("ovf_set", 32'(overflow), 32'd1);
        probe("v999_x29", 29, 12, 1299, rom_f(1299));
        load(5);
        wait_idle();
        check("ovf_clr", 32'(overflow), 32'd0);
        probe("v5_x20", 20, 0, 650, rom_f(650));

        // pending loads, latest wins
        cyc(1);
        relative_x = 10'd3; relative_y = 10'd0;
        load(100);
        cyc(2);
        load(200);
        cyc(3);
        load(300);
        wait_idle();
        probe("v300_x3", 3, 0, 393, rom_f(393));
        probe("v300_x10", 10, 0, 0, rom_f(0));

        // out of range
        probe("oor_x30", 30, 0, 0, TC);
        probe("oor_y13", 5, 13, 0, TC);

        // reset mid-conversion
        load(427);
        cyc(4);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy), 32'd0);
        probe("rst_x5", 5, 3, 35, lz_pix(35));

        // leading-zero behaviour
        load(7);
        wait_idle();
        probe("v7_x0", 0, 0, 0, lz_pix(0));
        probe("v7_x19", 19, 0, 9, lz_pix(9));
        probe("v7_x20", 20, 0, 910, rom_f(910));
        load(0);
        wait_idle();
        probe("v0_x25", 25, 3, 35, rom_f(35));
        probe("v0_x15", 15, 3, 35, lz_pix(35));

        cyc(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
